ddr_frame_arbiter: RTL

Sequences the single DDR command port shared by the camera write path and the LCD read path. It issues fixed-length write and read bursts with round-robin arbitration. It owns the frame-buffer addresses and swaps banks on frame boundaries, so the LCD always scans out the last completed camera frame. It sits in the `c3_clk0` domain between the camera/LCD staging FIFOs and the memory controller command interface.

---
 rtl/ddr_frame_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ddr_frame_arbiter.sv
// ddr_frame_arbiter
// Sequences the shared DDR command port between the camera write path and
// the LCD read path. Issues fixed-length bursts under round-robin
// arbitration, owns the frame-buffer word pointers and swaps banks on frame
// boundaries so the LCD always scans out the last completed camera frame.
//
// Build option: define FRAME_PINGPONG_EN for two-bank operation. Without it
// both banks are tied to 0 and every address is based on BANK0_BASE.
//
// Ports:
//   c3_clk0         controller clock (only clock)
//   reset_n         asynchronous active-low reset
//   calib_done      DDR calibration complete; gates all command issue
//   wr_fifo_count   words waiting in the camera write FIFO
//   wr_frame_start  camera frame-start pulse (synchronized)
//   rd_fifo_space   free words in the LCD read FIFO
//   rd_frame_start  LCD frame-start pulse (synchronized)
//   cmd_full        controller command FIFO full
//   cmd_en          command strobe, one cycle per command
//   cmd_instr       3'b000 write, 3'b001 read
//   cmd_bl          burst length minus one
//   cmd_byte_addr   burst start byte address
//   wr_bank         bank currently being written
//   rd_bank         bank currently being read
//   frame_drop_cnt  saturating count of incomplete camera frames
module ddr_frame_arbiter #(
  parameter int unsigned BURST_LEN   = 32,
  parameter int unsigned FRAME_WORDS = 32640,
  parameter logic [29:0] BANK0_BASE  = 30'h0000_0000,
  parameter logic [29:0] BANK1_BASE  = 30'h0040_0000
) (
  input  logic        c3_clk0,
  input  logic        reset_n,
  input  logic        calib_done,
  input  logic [6:0]  wr_fifo_count,
  input  logic        wr_frame_start,
  input  logic [6:0]  rd_fifo_space,
  input  logic        rd_frame_start,
  input  logic        cmd_full,
  output logic        cmd_en,
  output logic [2:0]  cmd_instr,
  output logic [5:0]  cmd_bl,
  output logic [29:0] cmd_byte_addr,
  output logic        wr_bank,
  output logic        rd_bank,
  output logic [7:0]  frame_drop_cnt
);

  localparam logic [6:0]  BURST_CNT = 7'(BURST_LEN);
  localparam logic [15:0] BURST_PTR = 16'(BURST_LEN);
  localparam logic [15:0] FRAME_PTR = 16'(FRAME_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_ISSUE, S_HOLD} state_t;

  state_t      state;
  logic [15:0] wr_ptr;
  logic [15:0] rd_ptr;
  logic        last_grant;
  logic [1:0]  holdoff;

  logic wr_elig;
  logic rd_elig;
  logic grant_rd;
  logic strobe;
  logic wr_done;

  function automatic logic [29:0] burst_addr(input logic bank, input logic [15:0] ptr);
    burst_addr = (bank ? BANK1_BASE : BANK0_BASE) + {11'd0, ptr, 3'd0};
  endfunction

  assign cmd_bl = 6'(BURST_LEN - 1);

  always_comb begin
    wr_elig  = (wr_fifo_count >= BURST_CNT) && (wr_ptr < FRAME_PTR);
    rd_elig  = (rd_fifo_space >= BURST_CNT) && (rd_ptr < FRAME_PTR);
    // Both eligible: serve the path that did not win last time.
    grant_rd = rd_elig && (!wr_elig || !last_grant);
    strobe   = calib_done && (state == S_ISSUE) && !cmd_full;
    wr_done  = (wr_ptr == FRAME_PTR);
  end

`ifdef FRAME_PINGPONG_EN
  logic wr_bank_nx;

  // The read side follows the write bank as it will be after this edge.
  assign wr_bank_nx = (wr_frame_start && wr_done) ? ~wr_bank : wr_bank;

  always_ff @(posedge c3_clk0 or negedge reset_n) begin
    if (!reset_n) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b1;
    end else begin
      wr_bank <= wr_bank_nx;
      if (rd_frame_start) rd_bank <= ~wr_bank_nx;
    end
  end
`else
  assign wr_bank = 1'b0;
  assign rd_bank = 1'b0;
`endif

  always_ff @(posedge c3_clk0 or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      cmd_en         <= 1'b0;
      cmd_instr      <= '0;
      cmd_byte_addr  <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      last_grant     <= 1'b1;
      holdoff        <= '0;
      frame_drop_cnt <= '0;
    end else begin
      cmd_en <= 1'b0;

      if (!calib_done) begin
        state <= S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: state <= S_ARB;
          S_ARB: begin
            if (wr_elig || rd_elig) begin
              cmd_instr     <= {2'b00, grant_rd};
              cmd_byte_addr <= grant_rd ? burst_addr(rd_bank, rd_ptr)
                                        : burst_addr(wr_bank, wr_ptr);
              state         <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            if (!cmd_full) begin
              cmd_en     <= 1'b1;
              last_grant <= cmd_instr[0];
              holdoff    <= 2'd2;
              state      <= S_HOLD;
            end
          end
          S_HOLD: begin
            holdoff <= holdoff - 2'd1;
            if (holdoff <= 2'd1) state <= S_ARB;
          end
          default: state <= S_IDLE;
        endcase
      end

      // Frame-start clears win over a same-cycle advance; the burst that
      // already went out keeps the address it was latched with.
      if (wr_frame_start) wr_ptr <= '0;
      else if (strobe && !cmd_instr[0]) wr_ptr <= wr_ptr + BURST_PTR;

      if (rd_frame_start) rd_ptr <= '0;
      else if (strobe && cmd_instr[0]) rd_ptr <= rd_ptr + BURST_PTR;

      if (wr_frame_start && !wr_done && (frame_drop_cnt != 8'hFF))
        frame_drop_cnt <= frame_drop_cnt + 8'd1;
    end
  end

endmodule
